// File: rtl/half_adder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// half_adder
//   Lane-wise half adder with an optional output pipeline and valid tracking.
//   Every lane is independent: sum[i] = a[i] ^ b[i], carry[i] = a[i] & b[i].
//   There is no carry propagation between lanes. carry_cnt reports how many
//   lanes produced a carry and is always aligned with carry.
//
// Parameters
//   WIDTH    number of independent 1-bit lanes (>= 1)
//   LATENCY  register stages from input to output (0..4); 0 = combinational
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset, clears every stage
//   in_valid   in   a/b carry a real operand this cycle
//   a, b       in   operands, one bit per lane
//   out_valid  out  in_valid delayed by LATENCY cycles
//   sum        out  per-lane a ^ b
//   carry      out  per-lane a & b
//   carry_cnt  out  popcount(carry)
// -----------------------------------------------------------------------------
module half_adder #(
  parameter int WIDTH   = 1,
  parameter int LATENCY = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           a,
  input  logic [WIDTH-1:0]           b,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           sum,
  output logic [WIDTH-1:0]           carry,
  output logic [$clog2(WIDTH+1)-1:0] carry_cnt
);

  localparam int CntW = $clog2(WIDTH + 1);

  // Out-of-range parameters stop elaboration instead of building odd hardware.
  if (WIDTH < 1 || LATENCY < 0 || LATENCY > 4) begin : g_bad_params
    $error("half_adder: WIDTH must be >= 1 and LATENCY must be in 0..4");
  end

  // One pipeline stage worth of result. Valid and data travel together so
  // carry_cnt can never drift out of step with carry.
  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] carry;
    logic [CntW-1:0]  cnt;
  } stage_t;

  function automatic logic [CntW-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [CntW-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt = cnt + CntW'(v[i]);
    end
    return cnt;
  endfunction

  stage_t stage_d;
  stage_t stage_o;

  // Result is computed once, up front; the pipeline only delays it.
  // X/Z on a lane stays confined to that lane's sum/carry (and the count).
  always_comb begin
    // NOTE: default the whole struct first so no path through this block can
    // leave a field unassigned and infer a latch.
    stage_d       = '0;
    stage_d.valid = in_valid;
    stage_d.sum   = a ^ b;
    stage_d.carry = a & b;
    stage_d.cnt   = popcount(a & b);
  end

  if (LATENCY == 0) begin : g_comb
    // Purely combinational: reset has no influence on the outputs here.
    assign stage_o = stage_d;
  end else begin : g_pipe
    stage_t stage_q [LATENCY];

    // Data stages load every cycle regardless of in_valid; out_valid is what
    // tells the consumer whether a result is meaningful.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        // NOTE: the data stages are cleared too, not only valid, because the
        // outputs must read zero throughout reset.
        for (int i = 0; i < LATENCY; i++) begin
          stage_q[i] <= '0;
        end
      end else begin
        // NOTE: non-blocking assignments make each stage take its
        // predecessor's old value, giving a true shift by one per clock.
        stage_q[0] <= stage_d;
        for (int i = 1; i < LATENCY; i++) begin
          stage_q[i] <= stage_q[i-1];
        end
      end
    end

    assign stage_o = stage_q[LATENCY-1];
  end

  assign out_valid = stage_o.valid;
  assign sum       = stage_o.sum;
  assign carry     = stage_o.carry;
  assign carry_cnt = stage_o.cnt;

endmodule

// File: tb/tb_half_adder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_half_adder
//   Four instances share clk/rst_n/in_valid:
//     u_d  : WIDTH=1, LATENCY=1 (defaults)
//     u_w4 : WIDTH=4, LATENCY=2
//     u_w8 : WIDTH=8, LATENCY=3
//     u_c0 : WIDTH=4, LATENCY=0 (own operand inputs)
//   Expected results are queued when stimulus is driven and compared when the
//   matching result reaches the instance's output.
// -----------------------------------------------------------------------------
module tb_half_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [0:0] a1, b1;
  logic [3:0] a4, b4, c0_a, c0_b;
  logic [7:0] a8, b8;

  logic       d_ov;  logic [0:0] d_sum, d_carry;  logic [0:0] d_cnt;
  logic       w4_ov; logic [3:0] w4_sum, w4_carry; logic [2:0] w4_cnt;
  logic       w8_ov; logic [7:0] w8_sum, w8_carry; logic [3:0] w8_cnt;
  logic       c0_ov; logic [3:0] c0_sum, c0_carry; logic [2:0] c0_cnt;

  always #5 clk = ~clk;

  half_adder u_d (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a1), .b(b1),
    .out_valid(d_ov), .sum(d_sum), .carry(d_carry), .carry_cnt(d_cnt)
  );

  half_adder #(.WIDTH(4), .LATENCY(2)) u_w4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a4), .b(b4),
    .out_valid(w4_ov), .sum(w4_sum), .carry(w4_carry), .carry_cnt(w4_cnt)
  );

  half_adder #(.WIDTH(8), .LATENCY(3)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a8), .b(b8),
    .out_valid(w8_ov), .sum(w8_sum), .carry(w8_carry), .carry_cnt(w8_cnt)
  );

  half_adder #(.WIDTH(4), .LATENCY(0)) u_c0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(c0_a), .b(c0_b),
    .out_valid(c0_ov), .sum(c0_sum), .carry(c0_carry), .carry_cnt(c0_cnt)
  );

  typedef struct {
    logic       v;
    logic [7:0] s;
    logic [7:0] c;
    int         cnt;
  } exp_t;

  typedef struct {
    logic a;
    logic b;
    logic s;
    logic c;
  } vec_t;

  exp_t q1[$];
  exp_t q4[$];
  exp_t q8[$];

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic v, input logic [7:0] av, input logic [7:0] bv,
                                 input int w);
    exp_t       e;
    logic [7:0] m;
    m     = 8'((1 << w) - 1);
    e.v   = v;
    e.s   = (av ^ bv) & m;
    e.c   = (av & bv) & m;
    e.cnt = $countones(e.c);
    return e;
  endfunction

  task automatic cmp(input string tag, input exp_t e, input logic ov, input logic [7:0] s,
                     input logic [7:0] c, input int cnt);
    check({tag, "_valid"}, 64'(ov), 64'(e.v));
    check({tag, "_sum"},   64'(s),  64'(e.s));
    check({tag, "_carry"}, 64'(c),  64'(e.c));
    check({tag, "_cnt"},   64'(cnt), 64'(e.cnt));
  endtask

  // Drive one cycle of stimulus (caller is already at the negedge), check the
  // combinational instance, then check whatever each pipeline now presents.
  task automatic drive(input logic v, input logic [7:0] av, input logic [7:0] bv);
    exp_t e;
    in_valid = v;
    a1 = av[0];   b1 = bv[0];
    a4 = av[3:0]; b4 = bv[3:0];
    a8 = av;      b8 = bv;
    c0_a = av[3:0]; c0_b = bv[3:0];
    q1.push_back(model(v, av, bv, 1));
    q4.push_back(model(v, av, bv, 4));
    q8.push_back(model(v, av, bv, 8));
    #1;
    e = model(v, av, bv, 4);
    cmp("c0", e, c0_ov, 8'(c0_sum), 8'(c0_carry), int'(c0_cnt));
    @(posedge clk);
    #1;
    if (q1.size() == 1) begin
      e = q1.pop_front();
      cmp("d", e, d_ov, 8'(d_sum), 8'(d_carry), int'(d_cnt));
    end
    if (q4.size() == 2) begin
      e = q4.pop_front();
      cmp("w4", e, w4_ov, 8'(w4_sum), 8'(w4_carry), int'(w4_cnt));
    end
    if (q8.size() == 3) begin
      e = q8.pop_front();
      cmp("w8", e, w8_ov, w8_sum, w8_carry, int'(w8_cnt));
    end
  endtask

  task automatic step(input logic v, input logic [7:0] av, input logic [7:0] bv);
    @(negedge clk);
    drive(v, av, bv);
  endtask

  task automatic check_pipes_zero(input string tag);
    check({tag, "_d_valid"},   64'(d_ov), 64'd0);
    check({tag, "_d_sum"},     64'(d_sum), 64'd0);
    check({tag, "_d_carry"},   64'(d_carry), 64'd0);
    check({tag, "_w4_valid"},  64'(w4_ov), 64'd0);
    check({tag, "_w4_carry"},  64'(w4_carry), 64'd0);
    check({tag, "_w4_cnt"},    64'(w4_cnt), 64'd0);
    check({tag, "_w8_valid"},  64'(w8_ov), 64'd0);
    check({tag, "_w8_sum"},    64'(w8_sum), 64'd0);
    check({tag, "_w8_carry"},  64'(w8_carry), 64'd0);
    check({tag, "_w8_cnt"},    64'(w8_cnt), 64'd0);
  endtask

  initial begin
    vec_t tbl[4];
    tbl[0] = '{a: 1'b0, b: 1'b0, s: 1'b0, c: 1'b0};
    tbl[1] = '{a: 1'b1, b: 1'b0, s: 1'b1, c: 1'b0};
    tbl[2] = '{a: 1'b0, b: 1'b1, s: 1'b1, c: 1'b0};
    tbl[3] = '{a: 1'b1, b: 1'b1, s: 1'b0, c: 1'b1};

    rst_n = 1'b0; in_valid = 1'b0;
    a1 = '0; b1 = '0; a4 = '0; b4 = '0; a8 = '0; b8 = '0; c0_a = '0; c0_b = '0;

    // Reset state
    #1;
    check_pipes_zero("init");
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 8'h00, 8'h00);

    // Exhaustive truth table on the default instance
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 8'(tbl[i].a), 8'(tbl[i].b));
      check($sformatf("tbl%0d_sum", i),   64'(d_sum),   64'(tbl[i].s));
      check($sformatf("tbl%0d_carry", i), 64'(d_carry), 64'(tbl[i].c));
      check($sformatf("tbl%0d_valid", i), 64'(d_ov),    64'd1);
    end

    // WIDTH=4, LATENCY=2 directed vectors
    step(1'b1, 8'h0C, 8'h0A);
    step(1'b1, 8'h0F, 8'h0F);
    check("w4_dir1_sum",   64'(w4_sum),   64'h6);
    check("w4_dir1_carry", 64'(w4_carry), 64'h8);
    check("w4_dir1_cnt",   64'(w4_cnt),   64'd1);
    check("w4_dir1_valid", 64'(w4_ov),    64'd1);
    step(1'b0, 8'h00, 8'h00);
    check("w4_dir2_sum",   64'(w4_sum),   64'h0);
    check("w4_dir2_carry", 64'(w4_carry), 64'hF);
    check("w4_dir2_cnt",   64'(w4_cnt),   64'd4);

    // Valid pattern 1,0,1,1 followed by idle flush
    step(1'b1, 8'h35, 8'h0F);
    step(1'b0, 8'hA5, 8'h5A);
    step(1'b1, 8'hFF, 8'h81);
    step(1'b1, 8'h12, 8'h34);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 8'h00);

    // Combinational instance responds without any clock edge
    c0_a = 4'h1; c0_b = 4'h1;
    #1;
    check("c0_nc_carry", 64'(c0_carry), 64'h1);
    check("c0_nc_sum",   64'(c0_sum),   64'h0);
    check("c0_nc_cnt",   64'(c0_cnt),   64'd1);
    c0_a = 4'hF; c0_b = 4'h5;
    #1;
    check("c0_nc2_sum",   64'(c0_sum),   64'hA);
    check("c0_nc2_carry", 64'(c0_carry), 64'h5);

    // Reset mid-stream with a=b=1 in flight
    step(1'b1, 8'hFF, 8'hFF);
    step(1'b1, 8'hFF, 8'hFF);
    #2;
    rst_n = 1'b0;
    #1;
    check_pipes_zero("rst_now");
    check("rst_c0_carry", 64'(c0_carry), 64'hF);
    check("rst_c0_valid", 64'(c0_ov),    64'd1);
    q1.delete(); q4.delete(); q8.delete();
    @(posedge clk);
    #1;
    check_pipes_zero("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 8'h01, 8'h00);
    check("post_rst_d_sum",   64'(d_sum),   64'd1);
    check("post_rst_d_carry", 64'(d_carry), 64'd0);
    check("post_rst_d_valid", 64'(d_ov),    64'd1);
    check("post_rst_w4_early_valid", 64'(w4_ov), 64'd0);
    check("post_rst_w8_early_valid", 64'(w8_ov), 64'd0);
    step(1'b0, 8'h00, 8'h00);
    step(1'b0, 8'h00, 8'h00);

    // Randomized stream across all widths
    for (int i = 0; i < 1000; i++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
    end
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
